// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the single-port data memory.
// Each legal access walks IDLE -> ISSUE -> WAIT -> DONE; illegal addresses go straight to DONE.
module data_memory_arbiter #(
  parameter int MEM_BYTES = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [31:0]       p0_data_i,
  output logic              p0_ack_o,
  output logic              p0_err_o,
  output logic [31:0]       p0_data_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_data_i,
  output logic              p1_ack_o,
  output logic              p1_err_o,
  output logic [31:0]       p1_data_o,
  output logic              mem_MemWrite_o,
  output logic              mem_MemRead_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  input  logic [31:0]       mem_data_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  logic [1:0]        state;
  logic              last_gnt;
  logic              gnt_port;
  logic              gnt_we;
  logic              pick;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [31:0]       pick_data;
  logic              pick_bad;

  // Tie goes to the port that was not granted last; otherwise whoever is asking.
  always_comb begin
    pick      = (p0_req_i && p1_req_i) ? ~last_gnt : p1_req_i;
    pick_we   = pick ? p1_we_i   : p0_we_i;
    pick_addr = pick ? p1_addr_i : p0_addr_i;
    pick_data = pick ? p1_data_i : p0_data_i;
    pick_bad  = (pick_addr[1:0] != 2'b00) || (pick_addr > LAST_WORD);
  end

  // mem_addr_o/mem_data_o double as the latched request fields for the access in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      last_gnt       <= 1'b1;
      gnt_port       <= 1'b0;
      gnt_we         <= 1'b0;
      p0_ack_o       <= 1'b0;
      p0_err_o       <= 1'b0;
      p0_data_o      <= '0;
      p1_ack_o       <= 1'b0;
      p1_err_o       <= 1'b0;
      p1_data_o      <= '0;
      mem_MemWrite_o <= 1'b0;
      mem_MemRead_o  <= 1'b0;
      mem_addr_o     <= '0;
      mem_data_o     <= '0;
    end else begin
      p0_ack_o       <= 1'b0;
      p0_err_o       <= 1'b0;
      p1_ack_o       <= 1'b0;
      p1_err_o       <= 1'b0;
      mem_MemWrite_o <= 1'b0;
      mem_MemRead_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_req_i || p1_req_i) begin
            last_gnt <= pick;
            gnt_port <= pick;
            gnt_we   <= pick_we;
            if (pick_bad) begin
              state    <= DONE;
              p0_ack_o <= ~pick;
              p0_err_o <= ~pick;
              p1_ack_o <= pick;
              p1_err_o <= pick;
            end else begin
              state          <= ISSUE;
              mem_MemWrite_o <= pick_we;
              mem_MemRead_o  <= ~pick_we;
              mem_addr_o     <= pick_addr;
              mem_data_o     <= pick_data;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          // Memory read data settled after the edge that ended ISSUE.
          state    <= DONE;
          p0_ack_o <= ~gnt_port;
          p1_ack_o <= gnt_port;
          if (!gnt_we) begin
            if (gnt_port) p1_data_o <= mem_data_i;
            else          p0_data_o <= mem_data_i;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
